// File: rtl/counter_pkg.sv
// Shared types and helpers for the run/pause/clear/direction counter sequencer.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int DEF_MAX_COUNT = 19;
  localparam int DEF_CNT_W     = 5;

  // One step of the 0..max_cnt ring in the requested direction.
  function automatic int unsigned next_count(input int unsigned cnt,
                                             input logic        dir_down,
                                             input int unsigned max_cnt);
    if (dir_down) begin
      return (cnt == 0) ? max_cnt : cnt - 1;
    end
    return (cnt >= max_cnt) ? 0 : cnt + 1;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a debounced button level; history tracks the level every
// cycle, so a button held through reset never produces an event.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    d_q <= d;
  end

  assign pulse = d & ~d_q & ~rst;

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/clear/direction sequencer: button edge detection, 3-state FSM, tick
// prescaler and the wrapping 0..MAX_COUNT up/down counter.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MAX_COUNT = DEF_MAX_COUNT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_clr,
  input  logic             btn_dir,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             dir_down,
  output logic             tick,
  output logic             wrap
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic evt_run, evt_clr, evt_dir;

  edge_rise u_edge_run (.clk(clk), .rst(rst), .d(btn_run), .pulse(evt_run));
  edge_rise u_edge_clr (.clk(clk), .rst(rst), .d(btn_clr), .pulse(evt_clr));
  edge_rise u_edge_dir (.clk(clk), .rst(rst), .d(btn_dir), .pulse(evt_dir));

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             dir_q, tick_q, wrap_q, running_q;

  logic             tick_d;
  logic [CNT_W-1:0] step_cnt_d;
  logic             step_wrap_d;

  assign tick_d      = (state_q == ST_RUN) && (div_q == DIV_W'(TICK_DIV - 1));
  assign step_cnt_d  = CNT_W'(next_count(32'(cnt_q), dir_q, 32'(MAX_COUNT)));
  assign step_wrap_d = dir_q ? (cnt_q == '0) : (cnt_q == CNT_W'(MAX_COUNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      dir_q     <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      // The step below reads dir_q, so a toggle on a tick edge only affects later steps.
      dir_q  <= dir_q ^ evt_dir;
      if (evt_clr) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        div_q     <= '0;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_q <= '0;
            div_q <= '0;
            if (evt_run) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (tick_d) begin
              div_q  <= '0;
              tick_q <= 1'b1;
              wrap_q <= step_wrap_d;
              cnt_q  <= step_cnt_d;
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
            if (evt_run) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (evt_run) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count    = cnt_q;
  assign running  = running_q;
  assign dir_down = dir_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl with TICK_DIV=4: vector table, directed corner sequences and
// randomized buttons checked against a cycle-level behavioural model.
module tb_counter_ctrl;

  localparam int TD   = 4;
  localparam int MAXC = 19;
  localparam int CW   = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_run = 1'b0, btn_clr = 1'b0, btn_dir = 1'b0;
  logic [CW-1:0] count;
  logic          running, dir_down, tick, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int   m_mode = M_IDLE;
  int   m_cnt = 0, m_phase = 0;
  logic m_dir = 1'b0, m_tick = 1'b0, m_wrap = 1'b0;
  logic p_run = 1'b0, p_clr = 1'b0, p_dir = 1'b0;

  counter_ctrl #(.TICK_DIV(TD), .MAX_COUNT(MAXC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_clr(btn_clr), .btn_dir(btn_dir),
    .count(count), .running(running), .dir_down(dir_down), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_step();
    logic er, ec, ed;
    er = btn_run & ~p_run;
    ec = btn_clr & ~p_clr;
    ed = btn_dir & ~p_dir;
    p_run = btn_run; p_clr = btn_clr; p_dir = btn_dir;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_phase = 0; m_dir = 1'b0;
      return;
    end
    if (ec) begin
      m_mode = M_IDLE; m_cnt = 0; m_phase = 0;
    end else if (m_mode == M_RUN) begin
      m_phase++;
      if (m_phase == TD) begin
        m_phase = 0;
        m_tick  = 1'b1;
        if (!m_dir) begin
          m_wrap = (m_cnt == MAXC);
          m_cnt  = (m_cnt + 1) % (MAXC + 1);
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + MAXC) % (MAXC + 1);
        end
      end
      if (er) m_mode = M_PAUSE;
    end else if (er) begin
      m_mode = M_RUN;
    end
    m_dir = m_dir ^ ed;
  endtask

  task automatic cyc(input logic r, input logic run, input logic clr, input logic dir);
    @(negedge clk);
    rst = r; btn_run = run; btn_clr = clr; btn_dir = dir;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic r, run, clr, dir;
    int   cnt;
    logic rn, dd, tk, wr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic run, input logic clr, input logic dir,
                              input int cnt, input logic rn, input logic dd,
                              input logic tk, input logic wr);
    vec_t v;
    v.r = r; v.run = run; v.clr = clr; v.dir = dir;
    v.cnt = cnt; v.rn = rn; v.dd = dd; v.tk = tk; v.wr = wr;
    return v;
  endfunction

  vec_t vt[19];

  initial begin
    int   k;
    logic nr, nc, nd, rr;

    // rst, run, clr, dir | count, running, dir_down, tick, wrap
    vt[0]  = mk(1, 1, 0, 0,  0, 0, 0, 0, 0);
    vt[1]  = mk(1, 1, 0, 0,  0, 0, 0, 0, 0);
    vt[2]  = mk(0, 1, 0, 0,  0, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0);
    vt[4]  = mk(0, 1, 0, 0,  0, 1, 0, 0, 0);
    vt[5]  = mk(0, 0, 0, 0,  0, 1, 0, 0, 0);
    vt[6]  = mk(0, 0, 0, 0,  0, 1, 0, 0, 0);
    vt[7]  = mk(0, 0, 0, 0,  0, 1, 0, 0, 0);
    vt[8]  = mk(0, 0, 0, 0,  1, 1, 0, 1, 0);
    vt[9]  = mk(0, 0, 0, 0,  1, 1, 0, 0, 0);
    vt[10] = mk(0, 0, 0, 1,  1, 1, 1, 0, 0);
    vt[11] = mk(0, 0, 0, 1,  1, 1, 1, 0, 0);
    vt[12] = mk(0, 0, 0, 0,  0, 1, 1, 1, 0);
    vt[13] = mk(0, 0, 0, 0,  0, 1, 1, 0, 0);
    vt[14] = mk(0, 0, 0, 0,  0, 1, 1, 0, 0);
    vt[15] = mk(0, 0, 0, 0,  0, 1, 1, 0, 0);
    vt[16] = mk(0, 0, 0, 0, 19, 1, 1, 1, 1);
    vt[17] = mk(0, 0, 1, 0,  0, 0, 1, 0, 0);
    vt[18] = mk(0, 0, 0, 0,  0, 0, 1, 0, 0);

    // Reset with run held, first steps, held dir button, wrap down, clear
    for (int i = 0; i < 19; i++) begin
      cyc(vt[i].r, vt[i].run, vt[i].clr, vt[i].dir);
      chk($sformatf("vec%0d {cnt,run,dir,tick,wrap}", i),
          int'({count, running, dir_down, tick, wrap}),
          int'({CW'(vt[i].cnt), vt[i].rn, vt[i].dd, vt[i].tk, vt[i].wr}));
    end

    // Full up-count cycle: 20 ticks, wrap only on 19->0
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2 running", int'(running), 1);
    k = 0;
    for (int i = 1; i <= 80; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("t2 tick@%0d", i), int'(tick), int'(i % 4 == 0));
      if (tick) begin
        k++;
        chk($sformatf("t2 cnt#%0d", k), int'(count), k % 20);
        chk($sformatf("t2 wrap#%0d", k), int'(wrap), int'(k % 20 == 0));
      end
    end
    chk("t2 tick total", k, 20);

    // Pause mid-period at count 7, resume finishes the partial period
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(28);
    chk("t3 cnt7", int'(count), 7);
    chk("t3 tick7", int'(tick), 1);
    idle(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3 paused", int'(running), 0);
    idle(5);
    chk("t3 held cnt", int'(count), 7);
    chk("t3 held tick", int'(tick), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3 resumed", int'(running), 1);
    idle(1);
    chk("t3 pre tick", int'(tick), 0);
    chk("t3 pre cnt", int'(count), 7);
    idle(1);
    chk("t3 tick", int'(tick), 1);
    chk("t3 cnt8", int'(count), 8);

    // Direction change at count 2, wrap 0->19, dir event on a tick edge
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    chk("t4 cnt2", int'(count), 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4 dir_down", int'(dir_down), 1);
    idle(3);
    chk("t4 cnt1", int'(count), 1);
    idle(4);
    chk("t4 cnt0", int'(count), 0);
    chk("t4 nowrap", int'(wrap), 0);
    idle(4);
    chk("t4 cnt19", int'(count), 19);
    chk("t4 wrap", int'(wrap), 1);
    idle(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4 old dir step", int'(count), 18);
    chk("t4 tick", int'(tick), 1);
    chk("t4 dir up", int'(dir_down), 0);
    idle(4);
    chk("t4 new dir step", int'(count), 19);
    chk("t4 up nowrap", int'(wrap), 0);

    // Clear and run together on a tick edge
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(7);
    chk("t5 cnt1", int'(count), 1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5 {cnt,run,tick,wrap}", int'({count, running, tick, wrap}), 0);
    idle(6);
    chk("t5 idle {cnt,run,tick}", int'({count, running, tick}), 0);

    // Reset mid-run at count 13 (counting down from an IDLE dir toggle)
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6 idle dir", int'(dir_down), 1);
    chk("t6 idle running", int'(running), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(28);
    chk("t6 cnt13", int'(count), 13);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6 rst {cnt,run,dir,tick,wrap}", int'({count, running, dir_down, tick, wrap}), 0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (tick || running || count != 0) k++;
    end
    chk("t6 quiet after rst", k, 0);

    // Randomized buttons against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 399) == 0);
      nr = btn_run ^ ($urandom_range(0, 7) == 0);
      nc = btn_clr ^ ($urandom_range(0, 39) == 0);
      nd = btn_dir ^ ($urandom_range(0, 9) == 0);
      cyc(rr, nr, nc, nd);
      chk($sformatf("rand%0d {cnt,run,dir,tick,wrap}", i),
          int'({count, running, dir_down, tick, wrap}),
          int'({CW'(m_cnt), (m_mode == M_RUN), m_dir, m_tick, m_wrap}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
